// File: rtl/retraso_n_pkg.sv
// Shared definitions for the retraso_n delay line: default sizing,
// pipeline operating modes and the delay_sel clamp helper.
package retraso_n_pkg;

  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DATA_W   = 6;
  localparam int DEF_DEPTH    = 4;

  // What the stage registers do on the coming clock edge.
  typedef enum logic [1:0] {
    MODE_SHIFT = 2'b00,
    MODE_STALL = 2'b01,
    MODE_FLUSH = 2'b10
  } pipe_mode_e;

  // Flush wins over stall; otherwise stall freezes, else the line shifts.
  function automatic pipe_mode_e decode_mode(input logic stall, input logic flush);
    if (flush)
      return MODE_FLUSH;
    else if (stall)
      return MODE_STALL;
    else
      return MODE_SHIFT;
  endfunction

  // Requested delays beyond the physical depth behave as the full depth.
  function automatic int clamp_sel(input int sel, input int depth);
    return (sel > depth) ? depth : sel;
  endfunction

endpackage

// File: rtl/retraso_n_if.sv
// Push/data bundle between the arbiters (master side) and the delay line
// (slave side). Channel c occupies push bit c and data slice [c*DATA_W +: DATA_W].
interface retraso_n_if
  import retraso_n_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DATA_W   = DEF_DATA_W
);

  logic [CHANNELS-1:0]        push_in;
  logic [CHANNELS*DATA_W-1:0] data_in;
  logic [CHANNELS-1:0]        push_out;
  logic [CHANNELS*DATA_W-1:0] data_out;

  modport master (
    output push_in,
    output data_in,
    input  push_out,
    input  data_out
  );

  modport slave (
    input  push_in,
    input  data_in,
    output push_out,
    output data_out
  );

endinterface

// File: rtl/retraso_n_etapa.sv
// One channel of the delay line: DEPTH-stage push/data shift register,
// output tap mux, in-flight push counter and sticky overrun flag.
module retraso_n_etapa
  import retraso_n_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SEL_W  = $clog2(DEPTH + 1),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [SEL_W-1:0]  sel,        // already clamped to 0..DEPTH
  input  logic              push_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  in_flight,
  output logic              overrun
);

  logic              push_s [1:DEPTH];
  logic [DATA_W-1:0] data_s [1:DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic              overrun_q;
  logic              tap_push;
  logic [DATA_W-1:0] tap_data;
  pipe_mode_e        mode;

  assign mode = decode_mode(stall, flush);

  // Stage registers, push accounting and overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        push_s[k] <= 1'b0;
        data_s[k] <= '0;
      end
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (mode)
        MODE_FLUSH: begin
          // Only the push bits are discarded; stale data is harmless
          // because nothing downstream qualifies it without a push.
          for (int k = 1; k <= DEPTH; k++)
            push_s[k] <= 1'b0;
          cnt_q     <= '0;
          overrun_q <= 1'b0;
        end
        MODE_STALL: begin
          if (push_in)
            overrun_q <= 1'b1;
        end
        MODE_SHIFT: begin
          push_s[1] <= push_in;
          data_s[1] <= data_in;
          for (int k = 2; k <= DEPTH; k++) begin
            push_s[k] <= push_s[k-1];
            data_s[k] <= data_s[k-1];
          end
          case ({push_in, push_s[DEPTH]})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Tap select: sel=0 bypasses the input, otherwise read stage sel.
  always_comb begin
    tap_push = push_in;
    tap_data = data_in;
    for (int k = 1; k <= DEPTH; k++) begin
      if (int'(sel) == k) begin
        tap_push = push_s[k];
        tap_data = data_s[k];
      end
    end
  end

  // A stalled line never presents a push, whatever the tap.
  assign push_out  = tap_push & ~stall;
  assign data_out  = tap_data;
  assign in_flight = cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/retraso_n.sv
// Multi-channel push/data delay line for the PCIe transmit path. Aligns
// push and data by 0..DEPTH cycles with global stall and flush, per-channel
// in-flight accounting and sticky overrun flags.
module retraso_n
  import retraso_n_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int SEL_W    = $clog2(DEPTH + 1),
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [SEL_W-1:0]          delay_sel,
  retraso_n_if.slave                bus,
  output logic [CHANNELS*CNT_W-1:0] in_flight,
  output logic [CHANNELS-1:0]       overrun,
  output logic                      busy
);

  logic [SEL_W-1:0]           sel_eff;
  logic [CHANNELS-1:0]        push_out_w;
  logic [CHANNELS*DATA_W-1:0] data_out_w;

  assign sel_eff = SEL_W'(clamp_sel(int'(delay_sel), DEPTH));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    retraso_n_etapa #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W),
      .CNT_W  (CNT_W)
    ) u_etapa (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .sel       (sel_eff),
      .push_in   (bus.push_in[c]),
      .data_in   (bus.data_in[c*DATA_W +: DATA_W]),
      .push_out  (push_out_w[c]),
      .data_out  (data_out_w[c*DATA_W +: DATA_W]),
      .in_flight (in_flight[c*CNT_W +: CNT_W]),
      .overrun   (overrun[c])
    );
  end

  assign bus.push_out = push_out_w;
  assign bus.data_out = data_out_w;

  // Busy whenever any channel still holds a queued push.
  always_comb begin
    busy = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      busy = busy | (|in_flight[c*CNT_W +: CNT_W]);
  end

endmodule

// File: tb/tb_retraso_n.sv
// Directed and randomised checks for retraso_n (2 channels, 6-bit data, depth 4).
module tb_retraso_n;
  import retraso_n_pkg::*;

  localparam int CH    = 2;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int SW    = 3;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              flush;
  logic [SW-1:0]     delay_sel;
  logic [CH*CW-1:0]  in_flight;
  logic [CH-1:0]     overrun;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  retraso_n_if #(.CHANNELS(CH), .DATA_W(DW)) bus ();

  retraso_n #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .delay_sel (delay_sel),
    .bus       (bus),
    .in_flight (in_flight),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] p, input logic [5:0] d1, input logic [5:0] d0);
    bus.push_in = p;
    bus.data_in = {d1, d0};
  endtask

  logic [DEPTH:1]   m [CH];
  logic [CH-1:0]    om;
  logic [CH-1:0]    e_po;
  logic [CH*CW-1:0] e_if;
  logic [1:0]       rp;
  logic             rst_v, rfl_v;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; delay_sel = 3'd2;
    drive(2'b00, 6'h00, 6'h00);
    cyc();
    #1;
    chk_eq("rst_push_out", bus.push_out, 0);
    chk_eq("rst_data_out", bus.data_out, 0);
    chk_eq("rst_in_flight", in_flight, 0);
    chk_eq("rst_overrun", overrun, 0);
    chk_eq("rst_busy", busy, 0);
    reset = 1'b0;
    cyc();

    // 1: delay 2, single push on ch0
    drive(2'b01, 6'h00, 6'h2A); #1;
    chk_eq("t1_c0_push", bus.push_out, 0);
    cyc(); drive(2'b00, 6'h00, 6'h00); #1;
    chk_eq("t1_c1_push", bus.push_out, 0);
    chk_eq("t1_c1_if", in_flight, 1);
    cyc(); #1;
    chk_eq("t1_c2_push", bus.push_out, 1);
    chk_eq("t1_c2_data", bus.data_out[5:0], 6'h2A);
    chk_eq("t1_c2_if", in_flight, 1);
    cyc(); #1;
    chk_eq("t1_c3_push", bus.push_out, 0);
    chk_eq("t1_c3_if", in_flight, 1);
    cyc(); #1;
    chk_eq("t1_c4_if", in_flight, 1);
    cyc(); #1;
    chk_eq("t1_c5_if", in_flight, 0);
    chk_eq("t1_c5_busy", busy, 0);
    cyc();

    // 2: delay 0 bypass
    delay_sel = 3'd0;
    drive(2'b11, 6'h15, 6'h0A); #1;
    chk_eq("t2_push", bus.push_out, 2'b11);
    chk_eq("t2_data", bus.data_out, 12'h54A);
    cyc(); drive(2'b00, 6'h00, 6'h00); #1;
    chk_eq("t2_c1_if", in_flight, 6'o11);
    chk_eq("t2_c1_push", bus.push_out, 0);
    chk_eq("t2_c1_busy", busy, 1);
    cyc(); cyc(); cyc(); #1;
    chk_eq("t2_c4_if", in_flight, 6'o11);
    cyc(); #1;
    chk_eq("t2_c5_if", in_flight, 0);
    cyc();

    // 3: delay 3, continuous pushes, two-cycle stall, then flush
    delay_sel = 3'd3;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 6'(k + 33), 6'(k + 1)); #1;
      if (k == 3) begin
        chk_eq("t3_first_push", bus.push_out, 2'b11);
        chk_eq("t3_first_d0", bus.data_out[5:0], 1);
        chk_eq("t3_first_d1", bus.data_out[11:6], 33);
      end else begin
        chk_eq("t3_fill_push", bus.push_out, 0);
      end
      cyc();
    end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 6'h3F, 6'h3F); #1;
      chk_eq("t3_stall_push", bus.push_out, 0);
      chk_eq("t3_stall_data", bus.data_out[5:0], 2);
      chk_eq("t3_stall_ovr", overrun, (i == 1) ? 2'b11 : 2'b00);
      cyc();
    end
    stall = 1'b0;
    drive(2'b11, 6'd37, 6'd5); #1;
    chk_eq("t3_resume_push", bus.push_out, 2'b11);
    chk_eq("t3_resume_d0", bus.data_out[5:0], 2);
    chk_eq("t3_resume_ovr", overrun, 2'b11);
    cyc();
    drive(2'b00, 6'h00, 6'h00); #1;
    chk_eq("t3_c7_push", bus.push_out, 2'b11);
    chk_eq("t3_c7_d0", bus.data_out[5:0], 3);
    chk_eq("t3_c7_d1", bus.data_out[11:6], 35);
    chk_eq("t3_c7_if", in_flight, 6'o44);
    cyc();
    flush = 1'b1; #1;
    chk_eq("t3_flush_push", bus.push_out, 2'b11);
    chk_eq("t3_flush_d0", bus.data_out[5:0], 4);
    chk_eq("t3_flush_if", in_flight, 6'o33);
    chk_eq("t3_flush_ovr", overrun, 2'b11);
    cyc();
    flush = 1'b0; #1;
    chk_eq("t3_post_ovr", overrun, 0);
    chk_eq("t3_post_if", in_flight, 0);
    chk_eq("t3_post_busy", busy, 0);
    chk_eq("t3_post_push", bus.push_out, 0);
    cyc();

    // 4: three pushes on ch1, flush while stalled
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 6'(k + 10), 6'h00); #1;
      cyc();
    end
    drive(2'b00, 6'h00, 6'h00);
    stall = 1'b1; flush = 1'b1; #1;
    chk_eq("t4_pre_if", in_flight, 6'o30);
    chk_eq("t4_pre_push", bus.push_out, 0);
    cyc();
    stall = 1'b0; flush = 1'b0; #1;
    chk_eq("t4_if", in_flight, 0);
    chk_eq("t4_busy", busy, 0);
    chk_eq("t4_ovr", overrun, 0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk_eq("t4_no_push", bus.push_out, 0);
      cyc();
    end

    // 5: async reset mid-stream
    delay_sel = 3'd2;
    drive(2'b01, 6'h00, 6'h11); #1;
    cyc();
    drive(2'b01, 6'h00, 6'h12); #1;
    cyc();
    drive(2'b00, 6'h00, 6'h00); #1;
    chk_eq("t5_pre_push", bus.push_out, 1);
    chk_eq("t5_pre_data", bus.data_out[5:0], 6'h11);
    #2;
    reset = 1'b1; #1;
    chk_eq("t5_rst_push", bus.push_out, 0);
    chk_eq("t5_rst_data", bus.data_out, 0);
    chk_eq("t5_rst_if", in_flight, 0);
    chk_eq("t5_rst_busy", busy, 0);
    cyc();
    reset = 1'b0;
    drive(2'b01, 6'h00, 6'h33); #1;
    chk_eq("t5_r0_push", bus.push_out, 0);
    cyc();
    drive(2'b00, 6'h00, 6'h00); #1;
    chk_eq("t5_r1_push", bus.push_out, 0);
    cyc(); #1;
    chk_eq("t5_r2_push", bus.push_out, 1);
    chk_eq("t5_r2_data", bus.data_out[5:0], 6'h33);
    cyc(); cyc(); cyc();

    // 6: delay_sel beyond depth clamps to depth
    delay_sel = 3'd7;
    drive(2'b10, 6'h2C, 6'h00); #1;
    cyc();
    drive(2'b00, 6'h00, 6'h00);
    for (int i = 1; i <= DEPTH; i++) begin
      #1;
      chk_eq("t6_push", bus.push_out, (i == DEPTH) ? 2'b10 : 2'b00);
      if (i == DEPTH)
        chk_eq("t6_data", bus.data_out[11:6], 6'h2C);
      cyc();
    end
    #1;
    chk_eq("t6_after", bus.push_out, 0);
    chk_eq("t6_if", in_flight, 0);
    cyc();

    // Random push/stall/flush against a push-bit model, effective delay 4
    for (int c = 0; c < CH; c++) m[c] = '0;
    om = '0;
    for (int n = 0; n < 10000; n++) begin
      rp    = 2'($urandom_range(0, 3));
      rst_v = ($urandom_range(0, 7) == 0);
      rfl_v = ($urandom_range(0, 31) == 0);
      drive(rp, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      stall = rst_v; flush = rfl_v; #1;
      for (int c = 0; c < CH; c++) begin
        e_po[c] = rst_v ? 1'b0 : m[c][DEPTH];
        e_if[c*CW +: CW] = CW'($countones(m[c]));
      end
      chk_eq("rnd_if", in_flight, e_if);
      chk_eq("rnd_push", bus.push_out, e_po);
      chk_eq("rnd_ovr", overrun, om);
      chk_eq("rnd_busy", busy, (e_if != 0) ? 1 : 0);
      if (rfl_v) begin
        for (int c = 0; c < CH; c++) m[c] = '0;
        om = '0;
      end else if (rst_v) begin
        om = om | rp;
      end else begin
        for (int c = 0; c < CH; c++) m[c] = {m[c][DEPTH-1:1], rp[c]};
      end
      cyc();
    end
    stall = 1'b0; flush = 1'b0;
    drive(2'b00, 6'h00, 6'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
